// File: rtl/freq_pkg.sv
// ---------------------------------------------------------------------------
// Package: freq_pkg
// Shared definitions for the frequency-measurement scheduler:
//   - FSM state encoding (IDLE..DONE) as plain 3-bit constants
//   - default settle / timeout cycle counts
//   - f_next_set(): lowest set bit of a channel mask at or above an index
// ---------------------------------------------------------------------------
package freq_pkg;

    // Upper bound on channel count; the channel-search helper works on a
    // mask of this width (narrower masks are zero-extended by the caller).
    localparam int MAX_CH  = 16;

    // Width of the shared settle/timeout down-counter.
    localparam int TIMER_W = 32;

    localparam int DEF_SETTLE_CNT  = 1_000;
    localparam int DEF_TIMEOUT_CNT = 100_000;

    typedef logic [2:0] state_t;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_SELECT = 3'd1;
    localparam logic [2:0] ST_SETTLE = 3'd2;
    localparam logic [2:0] ST_START  = 3'd3;
    localparam logic [2:0] ST_WAIT   = 3'd4;
    localparam logic [2:0] ST_STORE  = 3'd5;
    localparam logic [2:0] ST_DONE   = 3'd6;

    // Returns the index of the lowest set bit of i_mask whose index is
    // >= i_from, or -1 when there is none. Scanning from the top down and
    // overwriting on every hit leaves the lowest qualifying index; the search
    // never wraps back below i_from.
    function automatic int f_next_set(input logic [MAX_CH-1:0] i_mask,
                                      input int                i_from);
        int v_idx;
        v_idx = -1;
        for (int i = MAX_CH - 1; i >= 0; i--) begin
            if ((i >= i_from) && i_mask[i]) begin
                v_idx = i;
            end
        end
        return v_idx;
    endfunction

endpackage

// File: rtl/freq_sched_timer.sv
// ---------------------------------------------------------------------------
// Module: freq_sched_timer
// Down-counter shared by the settle interval and the measurement timeout.
// Ports:
//   i_clk      system clock
//   i_srst     synchronous active-high reset (count -> 0)
//   i_load     load i_load_val (has priority over decrement)
//   i_load_val value to load
//   i_dec      decrement by one; holds at zero
//   o_zero     count is zero
// ---------------------------------------------------------------------------
module freq_sched_timer
    import freq_pkg::*;
(
    input  logic               i_clk,
    input  logic               i_srst,
    input  logic               i_load,
    input  logic [TIMER_W-1:0] i_load_val,
    input  logic               i_dec,
    output logic               o_zero
);

    logic [TIMER_W-1:0] r_count;

    always_ff @(posedge i_clk) begin
        if (i_srst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - TIMER_W'(1);
        end
    end

    assign o_zero = (r_count == '0);

endmodule

// File: rtl/freq_meas_scheduler.sv
// ---------------------------------------------------------------------------
// Module: freq_meas_scheduler
// Sequences one shared frequency-measurement core across NUM_CH test clocks.
// For every enabled channel: steer the clock mux, wait SETTLE_CNT cycles,
// pulse meas_start, wait for meas_done (or TIMEOUT_CNT cycles), then record
// the result (or a timeout flag) in a per-channel result bank.
// Ports:
//   sys_clk, sys_rst  clock / synchronous active-high reset
//   sweep_start       pulse: begin a sweep over ch_en (ignored while busy)
//   ch_en             channel enable mask, latched at sweep start
//   ch_sel            clock-mux select, changes only when a channel is selected
//   meas_start        one-cycle pulse to the measurement core
//   meas_done         one-cycle pulse from the core, meas_freq valid with it
//   meas_freq         measured frequency word
//   rd_ch             readback channel index
//   rd_data/rd_valid  stored result of rd_ch, one cycle after rd_ch
//   res_err           per-channel timeout flag of the last attempt
//   busy              high from sweep accept until the sweep ends
//   sweep_done        one-cycle pulse after the last enabled channel is stored
// ---------------------------------------------------------------------------
module freq_meas_scheduler
    import freq_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int CH_W        = 2,
    parameter int DATA_W      = 50,
    parameter int SETTLE_CNT  = DEF_SETTLE_CNT,
    parameter int TIMEOUT_CNT = DEF_TIMEOUT_CNT,
    parameter bit CONTINUOUS  = 1'b0
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              sweep_start,
    input  logic [NUM_CH-1:0] ch_en,
    output logic [CH_W-1:0]   ch_sel,
    output logic              meas_start,
    input  logic              meas_done,
    input  logic [DATA_W-1:0] meas_freq,
    input  logic [CH_W-1:0]   rd_ch,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic [NUM_CH-1:0] res_err,
    output logic              busy,
    output logic              sweep_done
);

    // -----------------------------------------------------------------------
    // Control registers
    // -----------------------------------------------------------------------
    state_t            r_state;
    logic [CH_W-1:0]   r_cur;      // channel being measured
    logic [CH_W-1:0]   r_ch_sel;   // mux select, held between channels
    logic [NUM_CH-1:0] r_en_q;     // enable mask frozen for this sweep
    logic              r_busy;

    logic [DATA_W-1:0] r_rd_data;
    logic              r_rd_valid;

    // -----------------------------------------------------------------------
    // Channel search
    // -----------------------------------------------------------------------
    int w_first_idx;   // lowest enabled channel of the live ch_en
    int w_next_idx;    // next enabled channel above r_cur in the latched mask

    assign w_first_idx = f_next_set(MAX_CH'(ch_en), 0);
    assign w_next_idx  = f_next_set(MAX_CH'(r_en_q), int'(r_cur) + 1);

    // -----------------------------------------------------------------------
    // Shared timer
    // -----------------------------------------------------------------------
    logic               w_tmr_load;
    logic [TIMER_W-1:0] w_tmr_val;
    logic               w_tmr_dec;
    logic               w_tmr_zero;

    always_comb begin
        w_tmr_load = 1'b0;
        w_tmr_val  = '0;
        w_tmr_dec  = 1'b0;
        case (r_state)
            ST_SELECT: begin
                w_tmr_load = 1'b1;
                w_tmr_val  = TIMER_W'(SETTLE_CNT - 1);
            end
            ST_START: begin
                w_tmr_load = 1'b1;
                w_tmr_val  = TIMER_W'(TIMEOUT_CNT - 1);
            end
            ST_SETTLE, ST_WAIT: begin
                w_tmr_dec = 1'b1;
            end
            default: begin
            end
        endcase
    end

    freq_sched_timer u_timer (
        .i_clk      (sys_clk),
        .i_srst     (sys_rst),
        .i_load     (w_tmr_load),
        .i_load_val (w_tmr_val),
        .i_dec      (w_tmr_dec),
        .o_zero     (w_tmr_zero)
    );

    // -----------------------------------------------------------------------
    // Measurement outcome in WAIT. A done arriving in the same cycle the
    // timer hits zero counts as a success, so the timeout term excludes it.
    // -----------------------------------------------------------------------
    logic w_meas_ok;
    logic w_meas_to;

    assign w_meas_ok = (r_state == ST_WAIT) && meas_done;
    assign w_meas_to = (r_state == ST_WAIT) && !meas_done && w_tmr_zero;

    // -----------------------------------------------------------------------
    // Sequencer
    // -----------------------------------------------------------------------
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state  <= ST_IDLE;
            r_cur    <= '0;
            r_ch_sel <= '0;
            r_en_q   <= '0;
            r_busy   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    // An empty mask gives nothing to measure: stay idle.
                    if (sweep_start && (ch_en != '0)) begin
                        r_en_q  <= ch_en;
                        r_cur   <= CH_W'(w_first_idx);
                        r_busy  <= 1'b1;
                        r_state <= ST_SELECT;
                    end
                end
                ST_SELECT: begin
                    r_ch_sel <= r_cur;
                    r_state  <= ST_SETTLE;
                end
                ST_SETTLE: begin
                    if (w_tmr_zero) begin
                        r_state <= ST_START;
                    end
                end
                ST_START: begin
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (w_meas_ok || w_meas_to) begin
                        r_state <= ST_STORE;
                    end
                end
                ST_STORE: begin
                    if (w_next_idx >= 0) begin
                        r_cur   <= CH_W'(w_next_idx);
                        r_state <= ST_SELECT;
                    end else begin
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    // Continuous mode re-samples the live enable mask so a
                    // running sweep loop can be stopped by clearing ch_en.
                    if (CONTINUOUS && (ch_en != '0)) begin
                        r_en_q  <= ch_en;
                        r_cur   <= CH_W'(w_first_idx);
                        r_state <= ST_SELECT;
                    end else begin
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Per-channel result bank. Each channel owns its data word, valid bit and
    // timeout flag; only the channel matching r_cur is written.
    // -----------------------------------------------------------------------
    logic [DATA_W-1:0] w_bank [NUM_CH];
    logic [NUM_CH-1:0] w_valid;
    logic [NUM_CH-1:0] w_err;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic [DATA_W-1:0] r_data;
            logic              r_valid;
            logic              r_err;
            logic              w_sel;

            assign w_sel = (r_cur == CH_W'(gi));

            always_ff @(posedge sys_clk) begin
                if (sys_rst) begin
                    r_data  <= '0;
                    r_valid <= 1'b0;
                    r_err   <= 1'b0;
                end else if (w_sel) begin
                    if (w_meas_ok) begin
                        r_data  <= meas_freq;
                        r_valid <= 1'b1;
                        r_err   <= 1'b0;
                    end else if (w_meas_to) begin
                        r_data  <= '0;
                        r_valid <= 1'b0;
                        r_err   <= 1'b1;
                    end
                end
            end

            assign w_bank[gi]  = r_data;
            assign w_valid[gi] = r_valid;
            assign w_err[gi]   = r_err;
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Readback: registered every cycle. A bank write in the same cycle is
    // seen one cycle later because both update on the same edge.
    // -----------------------------------------------------------------------
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else if (int'(rd_ch) < NUM_CH) begin
            r_rd_data  <= w_bank[rd_ch];
            r_rd_valid <= w_valid[rd_ch];
        end else begin
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign ch_sel     = r_ch_sel;
    assign meas_start = (r_state == ST_START);
    assign sweep_done = (r_state == ST_DONE);
    assign busy       = r_busy;
    assign res_err    = w_err;
    assign rd_data    = r_rd_data;
    assign rd_valid   = r_rd_valid;

endmodule

// File: tb/tb_freq_meas_scheduler.sv
// ---------------------------------------------------------------------------
// Testbench for freq_meas_scheduler. A behavioural core answers meas_start
// with meas_done lat[ch] cycles later carrying f[ch]. Expected meas_start
// channels, sweep_done start counts and readback results are queued by the
// stimulus and checked by a separate monitor.
// ---------------------------------------------------------------------------
module tb_freq_meas_scheduler;

    localparam int NCH  = 4;
    localparam int DW   = 50;
    localparam int SET  = 8;
    localparam int TOUT = 50;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          valid;
        logic [1:0]    ch;
    } rd_exp_t;

    logic            clk = 1'b0;
    logic            sys_rst = 1'b1;

    // main DUT (single-shot sweeps)
    logic            sweep_start = 1'b0;
    logic [NCH-1:0]  ch_en = '0;
    logic [1:0]      ch_sel;
    logic            meas_start;
    logic            meas_done = 1'b0;
    logic [DW-1:0]   meas_freq = '0;
    logic [1:0]      rd_ch = '0;
    logic [DW-1:0]   rd_data;
    logic            rd_valid;
    logic [NCH-1:0]  res_err;
    logic            busy;
    logic            sweep_done;

    // second DUT (continuous sweeps)
    logic            c_sweep_start = 1'b0;
    logic [NCH-1:0]  c_ch_en = '0;
    logic [1:0]      c_ch_sel;
    logic            c_meas_start;
    logic            c_meas_done = 1'b0;
    logic [DW-1:0]   c_meas_freq = '0;
    logic [1:0]      c_rd_ch = '0;
    logic [DW-1:0]   c_rd_data;
    logic            c_rd_valid;
    logic [NCH-1:0]  c_res_err;
    logic            c_busy;
    logic            c_sweep_done;

    always #5 clk = ~clk;

    freq_meas_scheduler #(
        .NUM_CH(NCH), .CH_W(2), .DATA_W(DW),
        .SETTLE_CNT(SET), .TIMEOUT_CNT(TOUT), .CONTINUOUS(1'b0)
    ) u_dut (
        .sys_clk(clk), .sys_rst(sys_rst), .sweep_start(sweep_start), .ch_en(ch_en),
        .ch_sel(ch_sel), .meas_start(meas_start), .meas_done(meas_done),
        .meas_freq(meas_freq), .rd_ch(rd_ch), .rd_data(rd_data), .rd_valid(rd_valid),
        .res_err(res_err), .busy(busy), .sweep_done(sweep_done)
    );

    freq_meas_scheduler #(
        .NUM_CH(NCH), .CH_W(2), .DATA_W(DW),
        .SETTLE_CNT(SET), .TIMEOUT_CNT(TOUT), .CONTINUOUS(1'b1)
    ) u_dut_c (
        .sys_clk(clk), .sys_rst(sys_rst), .sweep_start(c_sweep_start), .ch_en(c_ch_en),
        .ch_sel(c_ch_sel), .meas_start(c_meas_start), .meas_done(c_meas_done),
        .meas_freq(c_meas_freq), .rd_ch(c_rd_ch), .rd_data(c_rd_data), .rd_valid(c_rd_valid),
        .res_err(c_res_err), .busy(c_busy), .sweep_done(c_sweep_done)
    );

    // -----------------------------------------------------------------------
    // Bookkeeping
    // -----------------------------------------------------------------------
    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int sweep_cyc = 0;
    int c_sweep_cyc = 0;

    int      exp_start_q[$];
    int      exp_done_q[$];
    rd_exp_t rd_q[$];
    int      start_log[$];
    int      c_start_log[$];
    int      c_done_cnt = 0;
    int      starts_in_sweep = 0;
    logic    rd_strobe = 1'b0;
    logic    rd_pend = 1'b0;
    rd_exp_t mon_e;

    logic [DW-1:0] f [NCH];
    int            lat [NCH];
    logic [NCH-1:0] silent = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // -----------------------------------------------------------------------
    // Behavioural measurement cores
    // -----------------------------------------------------------------------
    initial begin : core_main
        int ch;
        int n;
        bit aborted;
        forever begin
            @(negedge clk);
            if (meas_start && !sys_rst) begin
                ch = int'(ch_sel);
                if (!silent[ch]) begin
                    n = lat[ch];
                    aborted = 1'b0;
                    for (int i = 0; i < n; i++) begin
                        @(posedge clk);
                        if (sys_rst) aborted = 1'b1;
                    end
                    if (!aborted) begin
                        #1;
                        meas_done = 1'b1;
                        meas_freq = f[ch];
                        @(posedge clk);
                        #1;
                        meas_done = 1'b0;
                    end
                end
            end
        end
    end

    initial begin : core_cont
        bit aborted;
        forever begin
            @(negedge clk);
            if (c_meas_start && !sys_rst) begin
                aborted = 1'b0;
                for (int i = 0; i < 5; i++) begin
                    @(posedge clk);
                    if (sys_rst) aborted = 1'b1;
                end
                if (!aborted) begin
                    #1;
                    c_meas_done = 1'b1;
                    c_meas_freq = 50'd777;
                    @(posedge clk);
                    #1;
                    c_meas_done = 1'b0;
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Monitors
    // -----------------------------------------------------------------------
    always @(negedge clk) begin
        if (sys_rst) begin
            starts_in_sweep = 0;
            rd_pend = 1'b0;
        end else begin
            if (meas_start) begin
                start_log.push_back(cyc);
                starts_in_sweep++;
                $display("meas_start ch_sel=%0d cyc=%0d", ch_sel, cyc);
                chk("meas_start_expected", longint'(exp_start_q.size() != 0), 1);
                if (exp_start_q.size() != 0) chk("meas_start_ch_sel", ch_sel, exp_start_q.pop_front());
            end
            if (sweep_done) begin
                $display("sweep_done starts=%0d cyc=%0d", starts_in_sweep, cyc);
                chk("sweep_done_expected", longint'(exp_done_q.size() != 0), 1);
                if (exp_done_q.size() != 0) chk("sweep_done_starts", starts_in_sweep, exp_done_q.pop_front());
                starts_in_sweep = 0;
            end
            if (rd_pend) begin
                chk("rd_expected", longint'(rd_q.size() != 0), 1);
                if (rd_q.size() != 0) begin
                    mon_e = rd_q.pop_front();
                    $display("readback ch=%0d data=%0d valid=%0d", mon_e.ch, rd_data, rd_valid);
                    chk($sformatf("rd_data_ch%0d", mon_e.ch), rd_data, mon_e.data);
                    chk($sformatf("rd_valid_ch%0d", mon_e.ch), rd_valid, mon_e.valid);
                end
            end
            rd_pend = rd_strobe;
        end
    end

    always @(negedge clk) begin
        if (!sys_rst) begin
            if (c_meas_start) begin
                c_start_log.push_back(cyc);
                $display("cont meas_start ch_sel=%0d cyc=%0d", c_ch_sel, cyc);
            end
            if (c_sweep_done) c_done_cnt++;
        end
    end

    // -----------------------------------------------------------------------
    // Stimulus helpers
    // -----------------------------------------------------------------------
    task automatic do_reset();
        @(posedge clk);
        #1;
        sys_rst = 1'b1;
        sweep_start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        sys_rst = 1'b0;
    endtask

    task automatic pulse_sweep();
        @(posedge clk);
        #1;
        sweep_start = 1'b1;
        sweep_cyc = cyc;
        @(posedge clk);
        #1;
        sweep_start = 1'b0;
    endtask

    task automatic rd_check(input int ch, input logic [DW-1:0] d, input logic v);
        rd_exp_t e;
        @(posedge clk);
        #1;
        rd_ch = 2'(ch);
        e.data = d;
        e.valid = v;
        e.ch = 2'(ch);
        rd_q.push_back(e);
        rd_strobe = 1'b1;
        @(posedge clk);
        #1;
        rd_strobe = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int max);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < max && !ok; i++) begin
            @(negedge clk);
            if (!busy) ok = 1'b1;
        end
        chk(name, ok, 1);
    endtask

    task automatic wait_starts(input string name, input int n, input int max);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < max && !ok; i++) begin
            @(negedge clk);
            if (start_log.size() >= n) ok = 1'b1;
        end
        chk(name, ok, 1);
    endtask

    task automatic drain(input string name);
        repeat (3) @(posedge clk);
        chk({name, "_start_q_empty"}, exp_start_q.size(), 0);
        chk({name, "_done_q_empty"}, exp_done_q.size(), 0);
        chk({name, "_rd_q_empty"}, rd_q.size(), 0);
    endtask

    // -----------------------------------------------------------------------
    // Tests
    // -----------------------------------------------------------------------
    initial begin : main
        bit ok;
        lat = '{5, 5, 5, 5};
        f = '{50'd0, 50'd0, 50'd0, 50'd0};

        // ---- 1: all channels, reset state ----
        do_reset();
        @(negedge clk);
        chk("rst_ch_sel", ch_sel, 0);
        chk("rst_meas_start", meas_start, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_res_err", res_err, 0);
        chk("rst_busy", busy, 0);
        chk("rst_sweep_done", sweep_done, 0);

        start_log.delete();
        f = '{50'd1000, 50'd2000, 50'd3000, 50'd4000};
        ch_en = 4'b1111;
        for (int c = 0; c < 4; c++) exp_start_q.push_back(c);
        exp_done_q.push_back(4);
        pulse_sweep();
        @(negedge clk);
        chk("t1_busy_high", busy, 1);
        wait_idle("t1_idle", 400);
        if (start_log.size() >= 2) begin
            chk("t1_first_start_latency", start_log[0] - sweep_cyc, SET + 2);
            chk("t1_channel_gap", start_log[1] - start_log[0], SET + 8);
        end
        chk("t1_res_err", res_err, 0);
        chk("t1_ch_sel_hold", ch_sel, 3);
        for (int c = 0; c < 4; c++) rd_check(c, f[c], 1'b1);
        drain("t1");

        // ---- 2: sparse mask, empty-mask sweep ignored ----
        do_reset();
        ch_en = 4'b0000;
        pulse_sweep();
        repeat (20) @(negedge clk);
        chk("t2_empty_mask_busy", busy, 0);
        f = '{50'd11, 50'd22, 50'd33, 50'd44};
        ch_en = 4'b1010;
        exp_start_q.push_back(1);
        exp_start_q.push_back(3);
        exp_done_q.push_back(2);
        pulse_sweep();
        wait_idle("t2_idle", 400);
        chk("t2_res_err", res_err, 0);
        rd_check(0, 50'd0, 1'b0);
        rd_check(1, 50'd22, 1'b1);
        rd_check(2, 50'd0, 1'b0);
        rd_check(3, 50'd44, 1'b1);
        drain("t2");

        // ---- 3: silent core on ch2 -> timeout, sweep continues ----
        do_reset();
        start_log.delete();
        f = '{50'd101, 50'd202, 50'd303, 50'd404};
        silent = 4'b0100;
        ch_en = 4'b1111;
        for (int c = 0; c < 4; c++) exp_start_q.push_back(c);
        exp_done_q.push_back(4);
        pulse_sweep();
        wait_idle("t3_idle", 600);
        silent = 4'b0000;
        chk("t3_res_err", res_err, 4'b0100);
        if (start_log.size() >= 4) chk("t3_timeout_gap", start_log[3] - start_log[2], TOUT + SET + 3);
        rd_check(1, 50'd202, 1'b1);
        rd_check(2, 50'd0, 1'b0);
        rd_check(3, 50'd404, 1'b1);
        drain("t3");

        // ---- 4: done one cycle late (timeout) then exactly at expiry ----
        do_reset();
        ch_en = 4'b0010;
        f[1] = 50'd55555;
        lat[1] = TOUT + 1;
        exp_start_q.push_back(1);
        exp_done_q.push_back(1);
        pulse_sweep();
        wait_idle("t4a_idle", 400);
        repeat (5) @(negedge clk);
        chk("t4a_res_err_late", res_err, 4'b0010);
        rd_check(1, 50'd0, 1'b0);
        f[1] = 50'd66666;
        lat[1] = TOUT;
        exp_start_q.push_back(1);
        exp_done_q.push_back(1);
        pulse_sweep();
        wait_idle("t4b_idle", 400);
        chk("t4b_res_err_edge", res_err, 4'b0000);
        rd_check(1, 50'd66666, 1'b1);
        lat[1] = 5;
        drain("t4");

        // ---- 5: ignored restart / mask change while busy, reset mid-WAIT ----
        do_reset();
        start_log.delete();
        lat = '{20, 20, 20, 20};
        f = '{50'd1, 50'd2, 50'd3, 50'd4};
        ch_en = 4'b1111;
        exp_start_q.push_back(0);
        exp_start_q.push_back(1);
        pulse_sweep();
        wait_starts("t5_first_start", 1, 200);
        ch_en = 4'b0001;
        pulse_sweep();
        wait_starts("t5_second_start", 2, 200);
        repeat (3) @(posedge clk);
        do_reset();
        @(negedge clk);
        chk("t5_rst_ch_sel", ch_sel, 0);
        chk("t5_rst_meas_start", meas_start, 0);
        chk("t5_rst_rd_data", rd_data, 0);
        chk("t5_rst_rd_valid", rd_valid, 0);
        chk("t5_rst_res_err", res_err, 0);
        chk("t5_rst_busy", busy, 0);
        chk("t5_rst_sweep_done", sweep_done, 0);
        repeat (100) @(negedge clk);
        chk("t5_no_restart_busy", busy, 0);
        chk("t5_no_restart_starts", start_log.size(), 2);
        lat = '{5, 5, 5, 5};
        f = '{50'd7, 50'd8, 50'd9, 50'd10};
        ch_en = 4'b0101;
        exp_start_q.push_back(0);
        exp_start_q.push_back(2);
        exp_done_q.push_back(2);
        pulse_sweep();
        wait_idle("t5_clean_idle", 400);
        for (int c = 0; c < 4; c++) rd_check(c, (c % 2 == 0) ? f[c] : 50'd0, (c % 2 == 0));
        drain("t5");

        // ---- 6: continuous mode, back-to-back single-channel sweeps ----
        c_start_log.delete();
        c_done_cnt = 0;
        c_ch_en = 4'b0001;
        @(posedge clk);
        #1;
        c_sweep_start = 1'b1;
        c_sweep_cyc = cyc;
        @(posedge clk);
        #1;
        c_sweep_start = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 400 && !ok; i++) begin
            @(negedge clk);
            if (c_start_log.size() >= 4) ok = 1'b1;
        end
        chk("t6_four_starts", ok, 1);
        c_ch_en = 4'b0000;
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (!c_busy) ok = 1'b1;
        end
        chk("t6_stops", ok, 1);
        repeat (10) @(negedge clk);
        chk("t6_total_starts", c_start_log.size(), 4);
        chk("t6_sweep_done_cnt", c_done_cnt, 4);
        if (c_start_log.size() >= 4) begin
            chk("t6_first_latency", c_start_log[0] - c_sweep_cyc, SET + 2);
            for (int k = 1; k < 4; k++) chk($sformatf("t6_gap%0d", k), c_start_log[k] - c_start_log[k-1], SET + 9);
        end
        chk("t6_res_err", c_res_err, 0);
        chk("t6_rd_data", c_rd_data, 777);
        chk("t6_rd_valid", c_rd_valid, 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
